inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
// - Inverse of the register-read decode stage: packs decoded fields (opcode, rd, rs1, rs2,
//   funct3, funct7, sign-extended imm) into RV32I 32-bit instruction words.
// - Streams each encoded word into the instruction memory write port at consecutive addresses.
// - Used by the program loader and the self-check bench to build imem images from field-level
//   descriptions. Also range-checks immediates and substitutes NOP for illegal entries.
// PARAMETERS
// - ADDR_W   default 10   imem word-address width; addresses wrap modulo 2**ADDR_W
// PORTS
// - clock       in   1       clock
// - reset       in   1       synchronous, active-high reset
// - start       in   1       pulse: begin a load session at base_addr (honoured only in IDLE)
// - base_addr   in   ADDR_W  first imem word address of the session
// - in_valid    in   1       field bundle valid
// - in_ready    out  1       encoder accepts a bundle this cycle
// - in_last     in   1       marks the final bundle of the session
// - in_opcode   in   7       inst[6:0] opcode (OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE)
// - in_rd       in   5       destination register
// - in_rs1      in   5       source register 1
// - in_rs2      in   5       source register 2
// - in_funct3   in   3       funct3
// - in_funct7   in   7       funct7 (OP only)
// - in_imm      in   32      immediate, same sign-extended form the decode stage emits
// - imem_we     out  1       imem write strobe, one cycle per word
// - imem_addr   out  ADDR_W  imem write address
// - imem_wdata  out  32      encoded instruction
// - busy        out  1       session in progress (LOAD or DRAIN)
// - done        out  1       one-cycle pulse when the last word has been written
// - err         out  1       sticky: at least one entry replaced by NOP this session
// - err_count   out  ADDR_W+1  number of entries replaced this session (saturating)
// BEHAVIOUR
// - Reset: state=IDLE; in_ready, imem_we, busy, done, err all 0.
//   imem_addr=0, imem_wdata=0x00000013, err_count=0. Pipeline valids are cleared.
// - FSM states and transitions:
//   - IDLE: start moves to LOAD; wr_ptr<=base_addr; err and err_count cleared.
//   - LOAD: in_ready=1. Handshake = in_valid&&in_ready. A handshake with in_last=1
//     moves to DRAIN.
//   - DRAIN: in_ready=0. Moves to DONE when both pipeline stages are empty.
//   - DONE: done=1 for one cycle, then IDLE.
//   - start is ignored in every state except IDLE.
// - Pipeline, two register stages, throughput one word per cycle, no back-pressure from imem:
//   - S1 captures the fields on the handshake edge.
//   - S2 registers the encoded word and address and asserts imem_we.
//   - Bundle accepted at edge k -> imem_we/addr/wdata valid in the cycle after edge k+1.
//   - Write address = wr_ptr, which increments by 1 per written word and wraps
//     2**ADDR_W-1 -> 0.
// - Encoding (standard RV32I fields):
//   - I-type (OP_IMM, JALR, LOAD): inst[31:20]=imm[11:0].
//   - R-type (OP): inst[31:25]=funct7.
//   - S-type (STORE): inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
//   - B-type (BRANCH): {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
//   - U-type (LUI, AUIPC): inst[31:12]=imm[31:12].
//   - J-type (JAL): {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//   - Fields a format does not use are forced to 0.
// - Legality checks; a failing entry writes NOP 0x00000013, sets err, increments err_count:
//   - I/S: imm must be a sign-extended 12-bit value.
//   - B: sign-extended 13-bit value with imm[0]=0.
//   - J: sign-extended 21-bit value with imm[0]=0.
//   - U: imm[11:0]=0.
//   - Any opcode not in the list above is illegal.
// - Illegal entries still consume an address and still count toward done.
// - err_count saturates at all-ones. err and err_count hold their values through IDLE
//   until the next start.
// - Reset mid-session aborts immediately: no further imem_we, in-flight words are discarded.
// - in_last on the first bundle is legal: a single-word session.
// TESTING
// - start, base=0x010; addi x1,x0,5 (OP_IMM,rd1,f3=0,imm=5), in_last=1
//   -> we@0x010 = 0x00500093, then done pulse, err=0.
// - Back-to-back: add x3,x1,x2; lui x5,imm=0x12345000; sw x2,4(x1)
//   -> 0x002081B3, 0x123452B7, 0x0020A223 at consecutive addresses, 1 word/cycle.
// - Control flow: jal x1,imm=0xFFFFFFFC -> 0xFFDFF0EF; beq x1,x2,imm=8 -> 0x00208463.
// - Illegal: BRANCH imm=3, then opcode 0x7F, then addi imm=0x800
//   -> three writes of 0x00000013, err=1, err_count=3.
// - Wrap: base=2**ADDR_W-1, two bundles -> writes at 2**ADDR_W-1 then 0;
//   start asserted during LOAD is ignored.
// - Reset asserted the cycle after a handshake
//   -> no imem_we afterwards, all outputs at reset values, next session behaves normally.

Source files
------------

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields into 32-bit instruction words and streams them into
// the imem write port at consecutive, wrapping addresses; illegal entries become NOP.
module inst_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [6:0]          in_opcode,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic signed [31:0]  in_imm,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     err_count
);

  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP     = 7'b0110011;
  localparam logic [6:0]  LUI    = 7'b0110111;
  localparam logic [6:0]  AUIPC  = 7'b0010111;
  localparam logic [6:0]  JAL    = 7'b1101111;
  localparam logic [6:0]  JALR   = 7'b1100111;
  localparam logic [6:0]  BRANCH = 7'b1100011;
  localparam logic [6:0]  LOAD   = 7'b0000011;
  localparam logic [6:0]  STORE  = 7'b0100011;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm;
  } fields_t;

  // Returns {legal, word}; the word is meaningless when legal is 0.
  function automatic logic [32:0] encode(input fields_t f);
    logic        legal;
    logic [31:0] w;
    logic [31:0] i;
    i     = f.imm;
    legal = 1'b1;
    w     = NOP;
    case (f.opcode)
      OP_IMM, JALR, LOAD: begin
        legal = (i[31:11] == {21{i[11]}});
        w     = {i[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      end
      OP: w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      STORE: begin
        legal = (i[31:11] == {21{i[11]}});
        w     = {i[11:5], f.rs2, f.rs1, f.funct3, i[4:0], f.opcode};
      end
      BRANCH: begin
        legal = (i[31:12] == {20{i[12]}}) && !i[0];
        w     = {i[12], i[10:5], f.rs2, f.rs1, f.funct3, i[4:1], i[11], f.opcode};
      end
      LUI, AUIPC: begin
        legal = (i[11:0] == 12'd0);
        w     = {i[31:12], f.rd, f.opcode};
      end
      JAL: begin
        legal = (i[31:20] == {12{i[20]}}) && !i[0];
        w     = {i[20], i[10:1], i[11], i[19:12], f.rd, f.opcode};
      end
      default: legal = 1'b0;
    endcase
    return {legal, w};
  endfunction

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (&v) ? v : v + (ADDR_W+1)'(1);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     err_count_q, err_count_d;
  fields_t             fields_p1_q, fields_p1_d;
  logic                vld_p1_q, vld_p1_d;
  logic [ADDR_W-1:0]   addr_p2_q, addr_p2_d;
  logic [31:0]         wdata_p2_q, wdata_p2_d;
  logic                vld_p2_q, vld_p2_d;
  fields_t             in_fields;
  logic [32:0]         enc;
  logic                hs;

  assign in_fields = {in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm};
  assign in_ready  = (state_q == S_LOAD);
  assign hs        = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    fields_p1_d = hs ? in_fields : fields_p1_q;
    vld_p1_d    = hs;
    addr_p2_d   = addr_p2_q;
    wdata_p2_d  = wdata_p2_q;
    vld_p2_d    = vld_p1_q;
    enc         = encode(fields_p1_q);

    // S1 -> S2: encode, legality-check and claim the next address
    if (vld_p1_q) begin
      addr_p2_d  = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
      wdata_p2_d = enc[32] ? enc[31:0] : NOP;
      if (!enc[32]) begin
        err_d       = 1'b1;
        err_count_d = sat_inc(err_count_q);
      end
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_LOAD;
        wr_ptr_d    = base_addr;
        err_d       = 1'b0;
        err_count_d = '0;
      end
      S_LOAD:  if (hs && in_last) state_d = S_DRAIN;
      S_DRAIN: if (!vld_p1_q && !vld_p2_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      addr_p2_q   <= '0;
      wdata_p2_q  <= NOP;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      addr_p2_q   <= addr_p2_d;
      wdata_p2_q  <= wdata_p2_d;
    end
  end

  // input -> S1: field capture only, qualified by vld_p1
  always_ff @(posedge clock) begin
    fields_p1_q <= fields_p1_d;
  end

  assign imem_we    = vld_p2_q;
  assign imem_addr  = addr_p2_q;
  assign imem_wdata = wdata_p2_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed RV32I vectors plus randomized sessions checked
// against a field-level arithmetic encoder model and an address/error scoreboard.
module tb_inst_encoder;
  localparam int AW = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [AW-1:0]      base_addr = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_last = 1'b0;
  logic [6:0]         in_opcode = '0;
  logic [4:0]         in_rd = '0;
  logic [4:0]         in_rs1 = '0;
  logic [4:0]         in_rs2 = '0;
  logic [2:0]         in_funct3 = '0;
  logic [6:0]         in_funct7 = '0;
  logic signed [31:0] in_imm = '0;
  logic               imem_we;
  logic [AW-1:0]      imem_addr;
  logic [31:0]        imem_wdata;
  logic               busy;
  logic               done;
  logic               err;
  logic [AW:0]        err_count;

  inst_encoder #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    time           t;
  } exp_t;

  exp_t        exp_q[$];
  time         we_t[$];
  int unsigned m_ptr  = 0;
  int          m_errs = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference encoder: field placement by shift/mask, legality by signed range.
  function automatic int unsigned ref_encode(input int unsigned op, input int unsigned rd,
      input int unsigned rs1, input int unsigned rs2, input int unsigned f3,
      input int unsigned f7, input int imm, output bit legal);
    int unsigned u;
    u = unsigned'(imm);
    legal = 1'b1;
    case (op)
      'h13, 'h67, 'h03: begin
        legal = (imm >= -2048) && (imm <= 2047);
        return ((u & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      'h33: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      'h23: begin
        legal = (imm >= -2048) && (imm <= 2047);
        return (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
               | ((u & 'h1F) << 7) | op;
      end
      'h63: begin
        legal = (imm >= -4096) && (imm <= 4095) && ((u & 1) == 0);
        return (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20)
               | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 'hF) << 8)
               | (((u >> 11) & 1) << 7) | op;
      end
      'h37, 'h17: begin
        legal = (u % 4096) == 0;
        return (u & 'hFFFF_F000) | (rd << 7) | op;
      end
      'h6F: begin
        legal = (imm >= -1048576) && (imm <= 1048575) && ((u & 1) == 0);
        return (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21)
               | (((u >> 11) & 1) << 20) | (((u >> 12) & 'hFF) << 12) | (rd << 7) | op;
      end
      default: begin
        legal = 1'b0;
        return 'h13;
      end
    endcase
  endfunction

  // Write monitor: every imem_we must match the oldest expectation, 1.5 cycles after accept.
  always @(negedge clock) begin
    if (imem_we) begin
      we_t.push_back($time);
      if (exp_q.size() == 0) begin
        check("unexpected_we", {31'd0, imem_we}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
        check("wr_latency", 32'($time - e.t), 32'd15);
      end
    end
  end

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    start = 1'b0;
    exp_q.delete();
    repeat (cycles) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'h0000_0013);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
  endtask

  task automatic start_session(input logic [AW-1:0] b);
    @(negedge clock);
    start = 1'b1;
    base_addr = b;
    @(posedge clock);
    m_ptr = b;
    m_errs = 0;
    @(negedge clock);
    start = 1'b0;
    check("sess_busy", {31'd0, busy}, 32'd1);
    check("sess_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input bit last, input logic [31:0] exp_w, input bit exp_bad);
    int   n;
    exp_t e;
    @(negedge clock);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    in_last = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    e.addr = m_ptr[AW-1:0];
    e.data = exp_w;
    e.t = $time;
    exp_q.push_back(e);
    m_ptr = (m_ptr + 1) % (1 << AW);
    if (exp_bad && m_errs < (1 << (AW + 1)) - 1) m_errs++;
  endtask

  task automatic send_rand(input bit last);
    logic [6:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int unsigned w;
    bit          lg;
    case ($urandom_range(0, 9))
      0: op = 7'h13;  1: op = 7'h33;  2: op = 7'h37;  3: op = 7'h17;  4: op = 7'h6F;
      5: op = 7'h67;  6: op = 7'h63;  7: op = 7'h03;  8: op = 7'h23;
      default: op = 7'($urandom_range(0, 127));
    endcase
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = $urandom_range(0, 8191) - 4096;
      2: imm = ($urandom_range(0, 'h1F_FFFF) - 'h10_0000) & ~32'd1;
      default: imm = $urandom & 32'hFFFF_F000;
    endcase
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3 = 3'($urandom); f7 = 7'($urandom);
    w = ref_encode(op, rd, rs1, rs2, f3, f7, int'(imm), lg);
    send(op, rd, rs1, rs2, f3, f7, imm, last, lg ? w : 32'h13, !lg);
  endtask

  task automatic end_session();
    int n;
    @(negedge clock);
    in_valid = 1'b0;
    in_last = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("end_err", {31'd0, err}, {31'd0, m_errs != 0});
    check("end_err_count", 32'(err_count), 32'(m_errs));
    check("end_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    apply_reset(3);
    check_reset_values();

    // single-word session
    start_session(4'h0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093, 1'b0);
    end_session();

    // back-to-back R/U/S
    we_t.delete();
    start_session(4'h3);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0020_81B3, 1'b0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7, 1'b0);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 1'b1, 32'h0020_A223, 1'b0);
    end_session();
    check("b2b_writes", 32'(we_t.size()), 32'd3);
    if (we_t.size() == 3) check("b2b_rate", 32'(we_t[2] - we_t[0]), 32'd20);

    // control flow
    start_session(4'h8);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFFDF_F0EF, 1'b0);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b1, 32'h0020_8463, 1'b0);
    end_session();

    // illegal entries
    start_session(4'h1);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 32'h13, 1'b1);
    send(7'h7F, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'h13, 1'b1);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b1, 32'h13, 1'b1);
    end_session();
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_count", 32'(err_count), 32'd3);

    // address wrap with a start pulse during LOAD
    start_session(4'hF);
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0010_0113, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    start = 1'b1;
    base_addr = 4'h5;
    @(negedge clock);
    start = 1'b0;
    send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b1, 32'h0020_0193, 1'b0);
    end_session();

    // reset the cycle after a handshake
    start_session(4'h6);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b0);
    apply_reset(1);
    repeat (5) @(negedge clock);
    check_reset_values();
    start_session(4'h2);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093, 1'b0);
    end_session();

    // err_count saturation across many illegal entries
    start_session(4'h0);
    for (int i = 0; i < 40; i++)
      send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, i == 39, 32'h13, 1'b1);
    end_session();
    check("sat_count", 32'(err_count), 32'd31);

    // randomized sessions
    for (int s = 0; s < 8; s++) begin
      int len;
      len = $urandom_range(1, 12);
      start_session(AW'($urandom));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clock);
          in_valid = 1'b0;
        end
        send_rand(k == len - 1);
      end
      end_session();
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
